result_uart_tx: RTL and testbench
=================================

// Module: result_uart_tx
// PURPOSE
//  Transmit side of the calculator's serial link. Takes one signed 16-bit ALU result and
//  formats it as ASCII decimal text: optional '-', digits without leading zeros, then CR LF.
//  Sends the text as 8N1 UART frames on TX, paced by the shared baud tick from baudrate_gen.
//  Mirrors uart_rx; sits between the alu result and the board TX pin.
// PARAMETERS
//  OVERSAMPLE  16  baud ticks per UART bit period; must be >= 2
//  IDLE_GAP    0   extra idle-high bit periods inserted after each stop bit
// PORTS
//  clk       in   1   system clock; the only clock
//  reset     in   1   synchronous, active-low reset (0 = reset)
//  baud      in   1   one-clk-wide enable pulse at OVERSAMPLE x bit rate
//  start     in   1   one-clk request; samples value/overflow in the same cycle
//  value     in   16  signed two's-complement result to send
//  overflow  in   1   ALU overflow flag; used only with RESULT_TX_OVF_EN
//  tx        out  1   UART serial output, idle high
//  busy      out  1   high from the cycle after an accepted start until the last frame ends
//  done      out  1   one-clk pulse when the last stop bit (plus gap) completes
// BEHAVIOUR
//  Reset (reset==0 at posedge clk): tx=1, busy=0, done=0, FSM=IDLE, all counters=0.
//   Reset mid-frame aborts immediately. The line returns high the next cycle. The rest of the message is dropped.
//  States: IDLE -> CONVERT -> LOAD -> SEND -> (LOAD | FINISH) -> IDLE.
//  IDLE: tx=1. Accepts a start only here. When start=1, latches value, sets neg=value[15],
//   sets mag=|value| as a 16-bit unsigned (-32768 -> 32768), and goes to CONVERT. busy=1 the next cycle.
//   A start that arrives while busy=1 is ignored. It is not queued.
//  CONVERT: double-dabble over mag into 5 BCD digits. Takes exactly 16 clk cycles and does not use the baud tick.
//   At the end, fills a char buffer of up to 8 chars:
//   neg ? '-'(0x2D) : none; digits from the first nonzero digit ('0' alone if mag==0); 0x0D; 0x0A.
//   Length L ranges from 3 ("0\r\n") to 8 ("-32768\r\n"). Index ptr=0.
//  LOAD: shift_reg <= buf[ptr]; bit counter=0; go to SEND. Takes 1 clk.
//  SEND: frame = start bit(0), data bits 0..7 LSB first, stop bit(1), then IDLE_GAP idle bits.
//   Each bit is held for exactly OVERSAMPLE baud pulses.
//   The tick counter starts at the first baud pulse after entering SEND.
//   The tx change is registered. tx updates on the clk after the tick that ends the previous bit.
//   After the stop bit and gap: if ptr==L-1 go to FINISH, else ptr+1 and go to LOAD.
//   Frames are back-to-back apart from IDLE_GAP and the 1-clk LOAD.
//  FINISH: done=1 for one clk, busy=0, go to IDLE. A start in the same cycle as done is ignored.
//   A start in the cycle after done is accepted.
//  value and overflow are sampled only when start is accepted. Later changes have no effect.
//  baud pulses during IDLE, CONVERT or LOAD are ignored. The tick counter is cleared on every LOAD.
// CONFIGURATION
//  RESULT_TX_OVF_EN defined: if overflow==1 when start is accepted, skips CONVERT and sends
//   "OVF\r\n" (0x4F 0x56 0x46 0x0D 0x0A, L=5). value is ignored.
//   In this case busy rises the cycle after start, the same as for a normal result.
//  RESULT_TX_OVF_EN undefined: the overflow port exists but is unused. value is always sent as a number.
// TESTING (OVERSAMPLE=16, IDLE_GAP=0, 1 baud pulse every 4 clk unless stated)
//  1) value=16'd1234, start -> tx bytes 31 32 33 34 0D 0A; each bit is 16 baud long; done pulses once.
//  2) value=16'h8000 -> 2D 33 32 37 36 38 0D 0A; value=16'hFFFF -> 2D 31 0D 0A.
//  3) value=0 -> 30 0D 0A (no leading-zero suppression to empty); value=10 -> 31 30 0D 0A.
//  4) start again mid-message with value=5 -> ignored; output still carries the first value; busy stays 1.
//  5) reset=0 during data bit 3 of the 2nd char -> next clk tx=1, busy=0; then start with value=7 -> 37 0D 0A.
//  6) RESULT_TX_OVF_EN with overflow=1, value=123 -> 4F 56 46 0D 0A; without the macro -> 31 32 33 0D 0A.

Source files
------------

// File: rtl/result_uart_tx.sv
// Formats a signed 16-bit ALU result as ASCII decimal text plus CR LF and sends it as 8N1 UART frames.
// Optional build macro RESULT_TX_OVF_EN: an accepted start with overflow set sends "OVF\r\n" instead of the value.
module result_uart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int IDLE_GAP   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               baud,
    input  logic               start,
    input  logic signed [15:0] value,
    input  logic               overflow,
    output logic               tx,
    output logic               busy,
    output logic               done
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONVERT = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam int TICK_W   = $clog2(OVERSAMPLE);
    localparam int LAST_BIT = 9 + IDLE_GAP;
    localparam int BIT_W    = $clog2(LAST_BIT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(LAST_BIT);
    localparam logic [63:0]       OVF_TEXT  = 64'h0000_000A_0D46_564F;

    logic [2:0]        state;
    logic [TICK_W-1:0] tick_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [3:0]        conv_cnt;
    logic [2:0]        ptr;
    logic [2:0]        last_ptr;
    logic              neg;
    logic [15:0]       mag;
    logic [19:0]       bcd;
    logic [63:0]       char_buf;
    logic [7:0]        shift_reg;

`ifdef RESULT_TX_OVF_EN
    logic ovf_take;
    assign ovf_take = overflow;
`else
    logic ovf_take;
    logic unused_ovf;
    assign ovf_take   = 1'b0;
    assign unused_ovf = overflow;
`endif

    function automatic logic [19:0] dabble_adjust(input logic [19:0] d);
        logic [19:0] r;
        for (int i = 0; i < 5; i++)
            r[4*i +: 4] = (d[4*i +: 4] >= 4'd5) ? d[4*i +: 4] + 4'd3 : d[4*i +: 4];
        return r;
    endfunction

    logic [19:0] bcd_adj;
    logic [19:0] bcd_next;
    logic [63:0] text;
    logic [3:0]  text_len;
    logic        lead;
    logic [3:0]  digit;

    // One double-dabble step; on the final step the text is assembled from the finished digits.
    always_comb begin
        bcd_adj  = dabble_adjust(bcd);
        bcd_next = {bcd_adj[18:0], mag[15]};
        text     = '0;
        text_len = '0;
        lead     = 1'b0;
        digit    = '0;
        if (neg) begin
            text[7:0] = 8'h2D;
            text_len  = 4'd1;
        end
        for (int d = 4; d >= 0; d--) begin
            digit = bcd_next[4*d +: 4];
            if (digit != 4'd0 || lead || d == 0) begin
                lead = 1'b1;
                text[{text_len[2:0], 3'b000} +: 8] = {4'h3, digit};
                text_len = text_len + 4'd1;
            end
        end
        text[{text_len[2:0], 3'b000} +: 8] = 8'h0D;
        text_len = text_len + 4'd1;
        text[{text_len[2:0], 3'b000} +: 8] = 8'h0A;
        text_len = text_len + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            conv_cnt <= '0;
            ptr      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        busy     <= 1'b1;
                        ptr      <= '0;
                        conv_cnt <= '0;
                        state    <= ovf_take ? S_LOAD : S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    conv_cnt <= conv_cnt + 4'd1;
                    if (conv_cnt == 4'd15)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    tx       <= 1'b0;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (baud) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (bit_cnt == BIT_LAST) begin
                                if (ptr == last_ptr) begin
                                    state <= S_FINISH;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end else begin
                                    ptr   <= ptr + 3'd1;
                                    state <= S_LOAD;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx      <= shift_reg[0];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers; the shifter back-fills ones so stop and gap bits fall out naturally.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    neg <= value[15];
                    mag <= value[15] ? 16'd0 - value : value;
                    bcd <= '0;
                    if (ovf_take) begin
                        char_buf <= OVF_TEXT;
                        last_ptr <= 3'd4;
                    end
                end
            end
            S_CONVERT: begin
                bcd <= bcd_next;
                mag <= {mag[14:0], 1'b0};
                if (conv_cnt == 4'd15) begin
                    char_buf <= text;
                    last_ptr <= 3'(text_len - 4'd1);
                end
            end
            S_LOAD: shift_reg <= char_buf[{ptr, 3'b000} +: 8];
            S_SEND: begin
                if (baud && tick_cnt == TICK_LAST)
                    shift_reg <= {1'b1, shift_reg[7:1]};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: decodes the TX line as a UART receiver and compares against text built from the value.
module tb_result_uart_tx;
`ifdef RESULT_TX_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               baud;
    logic               start;
    logic signed [15:0] value;
    logic               overflow;
    logic               tx;
    logic               busy;
    logic               done;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    result_uart_tx #(.OVERSAMPLE(16), .IDLE_GAP(0)) dut (
        .clk(clk), .reset(reset), .baud(baud), .start(start), .value(value),
        .overflow(overflow), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // One baud pulse every 4 clocks: 16 pulses -> 64 clocks per bit.
    initial begin
        baud = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 baud = 1'b1;
            @(posedge clk);
            #1 baud = 1'b0;
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Expected text from the value using ordinary decimal formatting.
    function automatic void build_expected(input logic signed [15:0] v, input bit ovf);
        int    a;
        string s;
        exp_q.delete();
        if (ovf && OVF_EN) begin
            exp_q = '{8'h4F, 8'h56, 8'h46, 8'h0D, 8'h0A};
            return;
        end
        a = v;
        if (a < 0) begin
            exp_q.push_back(8'h2D);
            a = -a;
        end
        s = $sformatf("%0d", a);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic send_start(input logic signed [15:0] v, input bit o);
        @(negedge clk);
        value = v; overflow = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = 16'($urandom); overflow = 1'($urandom);
    endtask

    // Waits for a start edge, then samples mid-bit; ok is 0 on timeout, bad start or bad stop.
    task automatic recv_byte(output logic [7:0] b, output bit ok);
        int n;
        ok = 1'b0; b = '0; n = 0;
        while (tx !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) return;
        repeat (32) @(negedge clk);
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk);
            b[i] = tx;
        end
        repeat (64) @(negedge clk);
        ok = (tx === 1'b1);
    endtask

    task automatic wait_done(output bit seen);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        seen = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; value = '0; overflow = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got tx=%b busy=%b done=%b want tx=1 busy=0 done=0", tx, busy, done);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_numbers();
        logic signed [15:0] vals[$];
        bit                 ovfs[$];
        logic [7:0]         b;
        bit                 ok, seen;
        int                 d0;
        vals = '{16'sd1234, 16'sh8000, 16'shFFFF, 16'sd0, 16'sd10, 16'sd123};
        ovfs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        repeat (3) begin
            vals.push_back(16'($urandom));
            ovfs.push_back(1'($urandom_range(0, 1)));
        end
        foreach (vals[k]) begin
            build_expected(vals[k], ovfs[k]);
            d0 = done_cnt;
            send_start(vals[k], ovfs[k]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_start value=%0d got %b want 1", vals[k], busy);
            end
            foreach (exp_q[j]) begin
                recv_byte(b, ok);
                checks++;
                if (!ok || b !== exp_q[j]) begin
                    errors++;
                    $display("FAIL char value=%0d ovf=%0d idx=%0d got %h frame_ok=%0d want %h",
                             vals[k], ovfs[k], j, b, ok, exp_q[j]);
                end
            end
            wait_done(seen);
            checks++;
            if (!seen || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_end value=%0d got done=%b busy=%b want done=1 busy=0", vals[k], done, busy);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (done_cnt != d0 + 1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL done_count value=%0d got pulses=%0d busy=%b want pulses=1 busy=0",
                         vals[k], done_cnt - d0, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] b;
        bit         ok, seen, stayed;
        int         d0;
        build_expected(16'sd1234, 1'b0);
        d0 = done_cnt;
        send_start(16'sd1234, 1'b0);
        repeat (2) @(negedge clk);
        value = 16'sd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (exp_q[j]) begin
            recv_byte(b, ok);
            checks++;
            if (!ok || b !== exp_q[j]) begin
                errors++;
                $display("FAIL ignore_char idx=%0d got %h frame_ok=%0d want %h", j, b, ok, exp_q[j]);
            end
            if (j == 0) begin
                value = 16'sd5; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ignore_busy got %b want 1", busy);
                end
            end
        end
        wait_done(seen);
        stayed = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
        end
        checks++;
        if (!seen || !stayed || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL ignore_not_queued got done_seen=%0d idle=%0d pulses=%0d want 1 1 1",
                     seen, stayed, done_cnt - d0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        bit         ok, seen, stayed;
        int         n, d0;
        d0 = done_cnt;
        send_start(16'sd1234, 1'b0);
        recv_byte(b, ok);
        n = 0;
        while (tx !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        repeat (32 + 64 * 4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        stayed = 1'b1;
        repeat (700) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
        end
        checks++;
        if (!stayed || done_cnt != d0) begin
            errors++;
            $display("FAIL reset_dropped got idle=%0d pulses=%0d want idle=1 pulses=0", stayed, done_cnt - d0);
        end
        build_expected(16'sd7, 1'b0);
        send_start(16'sd7, 1'b0);
        foreach (exp_q[j]) begin
            recv_byte(b, ok);
            checks++;
            if (!ok || b !== exp_q[j]) begin
                errors++;
                $display("FAIL after_reset_char idx=%0d got %h frame_ok=%0d want %h", j, b, ok, exp_q[j]);
            end
        end
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL after_reset_done got done=%b want 1", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        bit         ok, seen, stayed;
        build_expected(16'sd42, 1'b0);
        send_start(16'sd42, 1'b0);
        foreach (exp_q[j]) recv_byte(b, ok);
        wait_done(seen);
        value = 16'sd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stayed = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
        end
        checks++;
        if (!seen || !stayed) begin
            errors++;
            $display("FAIL start_with_done got done_seen=%0d idle=%0d want 1 1", seen, stayed);
        end
        build_expected(-16'sd5, 1'b0);
        send_start(-16'sd5, 1'b0);
        foreach (exp_q[j]) begin
            recv_byte(b, ok);
            checks++;
            if (!ok || b !== exp_q[j]) begin
                errors++;
                $display("FAIL neg5_char idx=%0d got %h frame_ok=%0d want %h", j, b, ok, exp_q[j]);
            end
        end
        wait_done(seen);
        @(negedge clk);
        value = 16'sd32767; overflow = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_after_done got busy=%b want 1", busy);
        end
        build_expected(16'sd32767, 1'b0);
        foreach (exp_q[j]) begin
            recv_byte(b, ok);
            checks++;
            if (!ok || b !== exp_q[j]) begin
                errors++;
                $display("FAIL max_char idx=%0d got %h frame_ok=%0d want %h", j, b, ok, exp_q[j]);
            end
        end
        wait_done(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL max_done got done=%b want 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_numbers();
        test_ignore_start();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
